psram_access_arbiter: RTL and testbench
=======================================

Name: psram_access_arbiter

Overview:
- Shares the single PSRAM controller command port between the camera frame uploader (write requester) and the frame downloader (read requester).
- Grants one requester at a time using a request/acknowledge handshake, and muxes that requester's command, address and write data to the controller.
- Routes read-data-valid only to the reader, and enforces the controller's command gap between bursts.
- Gives writes priority, because the camera cannot stall, with a bounded anti-starvation rule for reads. A watchdog protects against a requester that never releases.

Parameters:
- CMD_GAP, 18: idle cycles required between consecutive grants (controller tCMD).
- MAX_WR_STREAK, 3: maximum consecutive write grants while a read is pending.
- GRANT_TIMEOUT, 1023: maximum cycles one grant may be held before forced release.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- calib_done  in  1  PSRAM controller calibration complete
- wr_rq  in  1  write requester wants the bus; level, held for the whole burst
- wr_ack  out  1  write grant; level
- wr_cmd_en  in  1  write requester command strobe
- wr_addr  in  21  write burst address
- wr_data  in  32  write data
- rd_rq  in  1  read requester wants the bus; level
- rd_ack  out  1  read grant; level
- rd_cmd_en  in  1  read requester command strobe
- rd_addr  in  21  read burst address
- rd_data_valid  out  1  gated copy of mem_rd_data_valid
- mem_cmd  out  1  1 = write, 0 = read
- mem_cmd_en  out  1  command strobe to controller
- mem_addr  out  21  address to controller
- mem_wr_data  out  32  write data to controller
- mem_rd_data_valid  in  1  read data valid from controller
- owner  out  2  00 none, 01 writer, 10 reader
- err  out  1  sticky protocol/timeout error

Behaviour:
- Reset (asynchronous, immediate):
  - state = WAIT_CALIB.
  - wr_ack, rd_ack, mem_cmd_en, mem_cmd, rd_data_valid, err = 0.
  - owner = 00; mem_addr = 0; mem_wr_data = 0.
  - wr_streak = 0; gap and timeout counters = 0.
- States: WAIT_CALIB, IDLE, GRANT_WR, GRANT_RD, GAP. State and acks are registered.
- WAIT_CALIB: go to IDLE when calib_done = 1.
- IDLE:
  - If calib_done = 0: return to WAIT_CALIB.
  - Arbitration is sampled at a clock edge; the ack is high from the following cycle.
  - If only wr_rq is high: grant write.
  - If only rd_rq is high: grant read.
  - If both are high: grant read if wr_streak == MAX_WR_STREAK, otherwise grant write.
- wr_streak update:
  - Write grant with rd_rq = 1: wr_streak + 1, saturating at MAX_WR_STREAK.
  - Write grant with rd_rq = 0: wr_streak = 0.
  - Any read grant: wr_streak = 0.
- GRANT_WR:
  - wr_ack = 1, owner = 01, mem_cmd = 1.
  - mem_cmd_en = wr_cmd_en, combinational pass-through.
  - mem_addr = wr_addr, mem_wr_data = wr_data.
- GRANT_RD:
  - rd_ack = 1, owner = 10, mem_cmd = 0.
  - mem_cmd_en = rd_cmd_en; mem_addr = rd_addr.
- Release:
  - While granted, the owner's rq falling at an edge clears ack and owner on that edge.
  - The arbiter then enters GAP with the counter loaded to CMD_GAP-1.
- rd_data_valid:
  - Equals mem_rd_data_valid while in GRANT_RD, and for CMD_GAP cycles after leaving it; this covers trailing read data.
  - 0 otherwise.
- GAP:
  - mem_cmd_en = 0; the counter decrements each cycle.
  - At 0, go to IDLE, so the next ack is at the earliest CMD_GAP+1 cycles after release.
  - An rq held during GAP is served from IDLE.
- Watchdog:
  - The timeout counter clears on grant and increments each granted cycle.
  - On reaching GRANT_TIMEOUT: force release (ack low, enter GAP) and set err.
  - The requester must drop its rq before being re-granted; an rq still high at IDLE counts as a new request.
- Protocol errors: a non-owner cmd_en = 1, or any cmd_en in IDLE/GAP/WAIT_CALIB, sets err. The strobe is never forwarded.
- err clears only on reset.
- calib_done falling during a grant: the current grant completes normally; after GAP, the arbiter goes to WAIT_CALIB.
- Both rq deasserted in the same cycle as the IDLE decision: no grant.
- A requester whose rq is low at the grant edge is not granted; there is no speculative grant.
- Outside a grant, mem_addr and mem_wr_data hold their last values; mem_cmd_en is always 0 outside a grant.

Test Plan:
- calib_done = 0, wr_rq = 1 for 50 cycles -> wr_ack stays 0. Raise calib_done -> WAIT_CALIB to IDLE, wr_ack = 1 one cycle after wr_rq is sampled in IDLE, owner = 01.
- rd_rq = 1 with a 4-beat mem_rd_data_valid burst, then rd_rq dropped -> rd_data_valid mirrors all 4 beats, rd_ack falls 1 cycle after rd_rq, and the next wr_ack is no earlier than 19 cycles after release (CMD_GAP = 18).
- wr_rq and rd_rq held continuously, each requester releasing after 10 granted cycles -> grant order W, W, W, R, W, W, W, R; no read waits more than 3 write grants.
- rd_rq held for 1100 cycles without release -> forced release at 1023 granted cycles, err = 1, then the pending wr_rq is granted after the gap.
- During GRANT_WR, pulse rd_cmd_en -> mem_cmd_en unaffected, err = 1. Pulse wr_cmd_en with wr_addr = 0x1ABCD -> mem_cmd_en = 1, mem_cmd = 1, mem_addr = 0x1ABCD in the same cycle.
- Assert reset mid-GRANT_RD -> rd_ack, mem_cmd_en and rd_data_valid drop immediately, owner = 00, and after release the arbiter requires calib_done again.

Source files
------------

// File: rtl/psram_access_arbiter.sv
// Shares the PSRAM controller command port between the frame uploader (writer)
// and the frame downloader (reader). Writes win, bounded by an anti-starvation streak.
module psram_access_arbiter #(
    parameter int CMD_GAP       = 18,
    parameter int MAX_WR_STREAK = 3,
    parameter int GRANT_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        calib_done,
    input  logic        wr_rq,
    output logic        wr_ack,
    input  logic        wr_cmd_en,
    input  logic [20:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_rq,
    output logic        rd_ack,
    input  logic        rd_cmd_en,
    input  logic [20:0] rd_addr,
    output logic        rd_data_valid,
    output logic        mem_cmd,
    output logic        mem_cmd_en,
    output logic [20:0] mem_addr,
    output logic [31:0] mem_wr_data,
    input  logic        mem_rd_data_valid,
    output logic [1:0]  owner,
    output logic        err
);

    localparam int GAP_W = $clog2(CMD_GAP + 1);
    localparam int STR_W = $clog2(MAX_WR_STREAK + 1);
    localparam int TO_W  = $clog2(GRANT_TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CMD_GAP - 1);
    localparam logic [STR_W-1:0] STR_MAX  = STR_W'(MAX_WR_STREAK);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(GRANT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        WAIT_CALIB,
        IDLE,
        GRANT_WR,
        GRANT_RD,
        GAP
    } state_t;

    state_t             state;
    logic [GAP_W-1:0]   gap_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [STR_W-1:0]   wr_streak;
    logic               gap_after_rd;
    logic [20:0]        addr_hold;
    logic [31:0]        data_hold;

    logic wr_granted;
    logic rd_granted;
    logic proto_err;
    logic rd_wins;

    assign wr_granted = (state == GRANT_WR);
    assign rd_granted = (state == GRANT_RD);

    // The granted requester drives the controller directly; otherwise the last values hold.
    assign mem_cmd_en  = (wr_granted & wr_cmd_en) | (rd_granted & rd_cmd_en);
    assign mem_addr    = wr_granted ? wr_addr : (rd_granted ? rd_addr : addr_hold);
    assign mem_wr_data = wr_granted ? wr_data : data_hold;

    // Trailing read beats arrive during the gap that follows a read grant.
    assign rd_data_valid = mem_rd_data_valid & (rd_granted | ((state == GAP) & gap_after_rd));

    assign proto_err = (wr_cmd_en & ~wr_granted) | (rd_cmd_en & ~rd_granted);
    assign rd_wins   = rd_rq & (~wr_rq | (wr_streak == STR_MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= WAIT_CALIB;
            wr_ack       <= 1'b0;
            rd_ack       <= 1'b0;
            owner        <= 2'b00;
            mem_cmd      <= 1'b0;
            err          <= 1'b0;
            wr_streak    <= '0;
            gap_cnt      <= '0;
            to_cnt       <= '0;
            gap_after_rd <= 1'b0;
            addr_hold    <= '0;
            data_hold    <= '0;
        end else begin
            if (proto_err) begin
                err <= 1'b1;
            end
            if (wr_granted) begin
                addr_hold <= wr_addr;
                data_hold <= wr_data;
            end else if (rd_granted) begin
                addr_hold <= rd_addr;
            end

            case (state)
                WAIT_CALIB: begin
                    if (calib_done) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (!calib_done) begin
                        state <= WAIT_CALIB;
                    end else if (rd_wins) begin
                        state     <= GRANT_RD;
                        rd_ack    <= 1'b1;
                        owner     <= 2'b10;
                        mem_cmd   <= 1'b0;
                        to_cnt    <= '0;
                        wr_streak <= '0;
                    end else if (wr_rq) begin
                        state   <= GRANT_WR;
                        wr_ack  <= 1'b1;
                        owner   <= 2'b01;
                        mem_cmd <= 1'b1;
                        to_cnt  <= '0;
                        if (!rd_rq) begin
                            wr_streak <= '0;
                        end else if (wr_streak != STR_MAX) begin
                            wr_streak <= wr_streak + STR_W'(1);
                        end
                    end
                end
                GRANT_WR: begin
                    if (!wr_rq || (to_cnt == TO_LAST)) begin
                        if (wr_rq) begin
                            err <= 1'b1;
                        end
                        state        <= GAP;
                        wr_ack       <= 1'b0;
                        owner        <= 2'b00;
                        gap_cnt      <= GAP_LOAD;
                        gap_after_rd <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                GRANT_RD: begin
                    if (!rd_rq || (to_cnt == TO_LAST)) begin
                        if (rd_rq) begin
                            err <= 1'b1;
                        end
                        state        <= GAP;
                        rd_ack       <= 1'b0;
                        owner        <= 2'b00;
                        gap_cnt      <= GAP_LOAD;
                        gap_after_rd <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= calib_done ? IDLE : WAIT_CALIB;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= WAIT_CALIB;
            endcase
        end
    end

endmodule

// File: tb/tb_psram_access_arbiter.sv
// Directed bench for psram_access_arbiter: calibration gating, gap timing,
// write priority with read anti-starvation, watchdog, protocol errors and reset.
module tb_psram_access_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        calib_done;
    logic        wr_rq;
    logic        wr_ack;
    logic        wr_cmd_en;
    logic [20:0] wr_addr;
    logic [31:0] wr_data;
    logic        rd_rq;
    logic        rd_ack;
    logic        rd_cmd_en;
    logic [20:0] rd_addr;
    logic        rd_data_valid;
    logic        mem_cmd;
    logic        mem_cmd_en;
    logic [20:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_rd_data_valid;
    logic [1:0]  owner;
    logic        err;

    int checks = 0;
    int errors = 0;

    psram_access_arbiter #(
        .CMD_GAP(18),
        .MAX_WR_STREAK(3),
        .GRANT_TIMEOUT(1023)
    ) dut (
        .clk(clk),
        .reset(reset),
        .calib_done(calib_done),
        .wr_rq(wr_rq),
        .wr_ack(wr_ack),
        .wr_cmd_en(wr_cmd_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_rq(rd_rq),
        .rd_ack(rd_ack),
        .rd_cmd_en(rd_cmd_en),
        .rd_addr(rd_addr),
        .rd_data_valid(rd_data_valid),
        .mem_cmd(mem_cmd),
        .mem_cmd_en(mem_cmd_en),
        .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data_valid(mem_rd_data_valid),
        .owner(owner),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until the selected ack is high, bounded at 100 cycles.
    task automatic wait_ack(input bit want_rd, output int n);
        n = 0;
        while (!(want_rd ? rd_ack : wr_ack) && n < 100) begin
            tick();
            n++;
        end
    endtask

    int         n;
    int         tail;
    int         beats;
    int         ng;
    int         wcnt;
    int         rcnt;
    int         cyc;
    logic       seen;
    logic       prev_w;
    logic       prev_r;
    logic [7:0] order;

    initial begin
        reset = 1'b1; calib_done = 1'b0;
        wr_rq = 1'b0; wr_cmd_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_rq = 1'b0; rd_cmd_en = 1'b0; rd_addr = '0; mem_rd_data_valid = 1'b0;
        tick(); tick();
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_rd_ack", rd_ack, 0);
        chk("rst_owner", owner, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_cmd_en", mem_cmd_en, 0);
        chk("rst_mem_cmd", mem_cmd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wr_data", mem_wr_data, 0);
        chk("rst_rd_data_valid", rd_data_valid, 0);

        // No grant before calibration completes
        reset = 1'b0;
        wr_rq = 1'b1;
        seen = 1'b0;
        repeat (50) begin
            tick();
            seen |= wr_ack;
        end
        chk("no_ack_before_calib", seen, 0);
        calib_done = 1'b1;
        tick();
        chk("idle_ack_not_yet", wr_ack, 0);
        tick();
        chk("wr_grant_ack", wr_ack, 1);
        chk("wr_grant_owner", owner, 2'b01);
        chk("wr_grant_mem_cmd", mem_cmd, 1);

        // Write command pass-through in the same cycle
        wr_cmd_en = 1'b1; wr_addr = 21'h1ABCD; wr_data = 32'hDEADBEEF;
        #1;
        chk("wr_pass_cmd_en", mem_cmd_en, 1);
        chk("wr_pass_addr", mem_addr, 21'h1ABCD);
        chk("wr_pass_data", mem_wr_data, 32'hDEADBEEF);
        tick();
        wr_cmd_en = 1'b0;
        #1;
        chk("wr_pass_cmd_en_low", mem_cmd_en, 0);
        chk("err_clean_after_legal_cmd", err, 0);

        // Release write, read must wait CMD_GAP+1 cycles
        wr_rq = 1'b0;
        tick();
        chk("wr_release_ack", wr_ack, 0);
        chk("wr_release_owner", owner, 0);
        chk("addr_hold_after_release", mem_addr, 21'h1ABCD);
        rd_rq = 1'b1;
        wait_ack(1'b1, n);
        chk("rd_after_gap_cycles", n, 19);
        chk("rd_grant_owner", owner, 2'b10);
        chk("rd_grant_mem_cmd", mem_cmd, 0);

        rd_cmd_en = 1'b1; rd_addr = 21'h0F00F;
        #1;
        chk("rd_pass_cmd_en", mem_cmd_en, 1);
        chk("rd_pass_addr", mem_addr, 21'h0F00F);
        tick();
        rd_cmd_en = 1'b0;

        // 4-beat read burst mirrored to the reader
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            mem_rd_data_valid = 1'b1;
            #1;
            if (rd_data_valid) beats++;
            tick();
        end
        mem_rd_data_valid = 1'b0;
        #1;
        chk("rd_burst_beats", beats, 4);
        chk("rd_valid_idle_low", rd_data_valid, 0);

        // Release read: tail window is exactly CMD_GAP cycles, next write at +19
        rd_rq = 1'b0;
        tick();
        chk("rd_release_ack", rd_ack, 0);
        wr_rq = 1'b1;
        mem_rd_data_valid = 1'b1;
        n = 0; tail = 0;
        while (!wr_ack && n < 100) begin
            #1;
            if (rd_data_valid) tail++;
            tick();
            n++;
        end
        chk("rd_tail_cycles", tail, 18);
        chk("wr_after_rd_gap_cycles", n, 19);
        #1;
        chk("rd_valid_gated_in_wr", rd_data_valid, 0);
        mem_rd_data_valid = 1'b0;
        chk("err_clean_before_arb", err, 0);

        // Both requesters held: W W W R W W W R
        wr_rq = 1'b0;
        tick();
        wr_rq = 1'b1; rd_rq = 1'b1;
        order = '0; ng = 0; wcnt = 0; rcnt = 0; cyc = 0;
        prev_w = 1'b0; prev_r = 1'b0;
        while (ng < 8 && cyc < 2000) begin
            tick();
            cyc++;
            if (wr_ack && !prev_w) begin
                order[ng] = 1'b0;
                ng++;
            end
            if (rd_ack && !prev_r && ng < 8) begin
                order[ng] = 1'b1;
                ng++;
            end
            prev_w = wr_ack;
            prev_r = rd_ack;
            if (wr_ack) begin
                wcnt++;
                if (wcnt == 10) begin
                    wr_rq = 1'b0;
                    wcnt = 0;
                end
            end else if (!wr_rq) begin
                wr_rq = 1'b1;
            end
            if (rd_ack) begin
                rcnt++;
                if (rcnt == 10) begin
                    rd_rq = 1'b0;
                    rcnt = 0;
                end
            end else if (!rd_rq) begin
                rd_rq = 1'b1;
            end
        end
        chk("arb_grant_count", ng, 8);
        chk("arb_grant_order", order, 8'h88);
        wr_rq = 1'b0; rd_rq = 1'b0;
        repeat (22) tick();

        // Watchdog: read never releases
        rd_rq = 1'b1;
        wait_ack(1'b1, n);
        chk("wd_rd_grant_from_idle", n, 1);
        chk("wd_err_before", err, 0);
        wr_rq = 1'b1;
        n = 0;
        while (rd_ack && n < 1100) begin
            n++;
            tick();
        end
        chk("wd_granted_cycles", n, 1023);
        chk("wd_err_set", err, 1);
        chk("wd_owner_cleared", owner, 0);
        wait_ack(1'b0, n);
        chk("wd_wr_after_gap", n, 19);
        chk("wd_wr_owner", owner, 2'b01);

        // Reset in the middle of a read grant
        wr_rq = 1'b0;
        tick();
        wait_ack(1'b1, n);
        chk("rd_regrant_gap", n, 19);
        mem_rd_data_valid = 1'b1; rd_cmd_en = 1'b1;
        #1;
        chk("pre_reset_rd_valid", rd_data_valid, 1);
        chk("pre_reset_cmd_en", mem_cmd_en, 1);
        reset = 1'b1;
        #1;
        chk("async_rst_rd_ack", rd_ack, 0);
        chk("async_rst_cmd_en", mem_cmd_en, 0);
        chk("async_rst_rd_valid", rd_data_valid, 0);
        chk("async_rst_owner", owner, 0);
        chk("async_rst_err", err, 0);
        rd_cmd_en = 1'b0; mem_rd_data_valid = 1'b0; calib_done = 1'b0;
        tick();
        reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen |= rd_ack;
        end
        chk("post_reset_needs_calib", seen, 0);
        calib_done = 1'b1;
        wait_ack(1'b1, n);
        chk("post_reset_calib_grant", n, 2);

        // Non-owner strobe during a write grant
        rd_rq = 1'b0; wr_rq = 1'b1;
        tick();
        wait_ack(1'b0, n);
        chk("wr_after_rd_release", n, 19);
        rd_cmd_en = 1'b1;
        #1;
        chk("nonowner_not_forwarded", mem_cmd_en, 0);
        chk("err_before_nonowner", err, 0);
        tick();
        rd_cmd_en = 1'b0;
        chk("nonowner_err_set", err, 1);

        // Calibration loss during a grant: grant continues, then WAIT_CALIB
        calib_done = 1'b0;
        tick();
        chk("calib_loss_grant_kept", wr_ack, 1);
        wr_rq = 1'b0; rd_rq = 1'b1;
        tick();
        seen = 1'b0;
        repeat (40) begin
            tick();
            seen |= rd_ack;
        end
        chk("calib_loss_no_grant", seen, 0);
        calib_done = 1'b1;
        wait_ack(1'b1, n);
        chk("calib_return_grant", n, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
